// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared constants and state encoding for the multi-port
//               register file (regfile_mp) and its write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

  // Default register width and register count.
  localparam int DATA_W_DEF = 32;
  localparam int NREGS_DEF  = 32;

  // Controller states: CLEAR sweeps storage to zero, READY accepts traffic.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wr_arbiter
// Description : Finds the highest-numbered enabled write port whose index
//               matches i_idx and returns its data with a hit flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wr_arbiter #(
  parameter int NWR    = 2,
  parameter int IDX_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [NWR-1:0]        i_wr_en,
  input  logic [NWR*IDX_W-1:0]  i_wr_idx,
  input  logic [NWR*DATA_W-1:0] i_wr_data,
  output logic                  o_hit,
  output logic [DATA_W-1:0]     o_data
);

  // Ascending scan: a later (higher-numbered) match overrides earlier ones.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int p = 0; p < NWR; p++) begin
      if (i_wr_en[p] && (i_wr_idx[p*IDX_W +: IDX_W] == i_idx)) begin
        o_hit  = 1'b1;
        o_data = i_wr_data[p*DATA_W +: DATA_W];
      end
    end
  end

endmodule : rf_wr_arbiter
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised NRD-read / NWR-write integer register file with
//               sequential clear engine, write-port priority (highest port
//               wins) and same-cycle write-to-read bypass.
//               Optional macro RF_SCOREBOARD_EN adds per-register busy bits.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
  import rf_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int NREGS  = NREGS_DEF,
  parameter  int NRD    = 4,
  parameter  int NWR    = 2,
  localparam int IDX_W  = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*IDX_W-1:0]  rd_idx,
  output logic [NRD*DATA_W-1:0] rd_data,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*IDX_W-1:0]  wr_idx,
  input  logic [NWR*DATA_W-1:0] wr_data,
`ifdef RF_SCOREBOARD_EN
  input  logic                  sb_set_en,
  input  logic [IDX_W-1:0]      sb_set_idx,
  output logic [NRD-1:0]        rd_busy,
`endif
  output logic                  ready
);

  rf_state_e         r_state;
  rf_state_e         w_state_nxt;
  logic [IDX_W-1:0]  r_clr_cnt;
  logic [IDX_W-1:0]  w_clr_cnt_nxt;

  // Storage carries no per-entry reset so it can map onto RAM.
  logic [DATA_W-1:0] r_mem [NREGS];

  // Per-entry resolved write (entry 0 is hard-wired and never written).
  logic [NREGS-1:1]  w_ent_hit;
  logic [DATA_W-1:0] w_ent_data [1:NREGS-1];

  // State register and clear counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // Next-state logic: sweep one entry per cycle, then go READY.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      CLEAR: begin
        w_clr_cnt_nxt = r_clr_cnt + IDX_W'(1);
        if (r_clr_cnt == IDX_W'(NREGS - 1)) begin
          w_state_nxt   = READY;
          w_clr_cnt_nxt = '0;
        end
      end
      READY: begin
        w_state_nxt = READY;
      end
      default: begin
        w_state_nxt   = CLEAR;
        w_clr_cnt_nxt = '0;
      end
    endcase
  end

  assign ready = (r_state == READY);

  // Resolve the winning write port for every writable entry.
  for (genvar i = 1; i < NREGS; i++) begin : g_entry
    rf_wr_arbiter #(
      .NWR    (NWR),
      .IDX_W  (IDX_W),
      .DATA_W (DATA_W)
    ) u_arb (
      .i_idx     (IDX_W'(i)),
      .i_wr_en   (wr_en),
      .i_wr_idx  (wr_idx),
      .i_wr_data (wr_data),
      .o_hit     (w_ent_hit[i]),
      .o_data    (w_ent_data[i])
    );
  end

  // Storage update: zero one entry per cycle while clearing, else commit writes.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (!reset) begin
      for (int i = 1; i < NREGS; i++) begin
        if (w_ent_hit[i]) begin
          r_mem[i] <= w_ent_data[i];
        end
      end
    end
  end

`ifdef RF_SCOREBOARD_EN
  logic [NREGS-1:0] r_busy;

  // Busy bits: set by scoreboard, cleared by a write; set wins a same-cycle tie.
  always_ff @(posedge clk) begin
    if (reset || ((r_state == CLEAR) && (r_clr_cnt == '0))) begin
      r_busy <= '0;
    end else if (r_state == READY) begin
      for (int i = 1; i < NREGS; i++) begin
        if (sb_set_en && (sb_set_idx == IDX_W'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (w_ent_hit[i]) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end
`endif

  // Read ports: zero during CLEAR and for index 0, bypass a same-cycle write.
  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [IDX_W-1:0]  w_idx;
    logic              w_hit;
    logic [DATA_W-1:0] w_byp;

    assign w_idx = rd_idx[r*IDX_W +: IDX_W];

    rf_wr_arbiter #(
      .NWR    (NWR),
      .IDX_W  (IDX_W),
      .DATA_W (DATA_W)
    ) u_arb (
      .i_idx     (w_idx),
      .i_wr_en   (wr_en),
      .i_wr_idx  (wr_idx),
      .i_wr_data (wr_data),
      .o_hit     (w_hit),
      .o_data    (w_byp)
    );

    assign rd_data[r*DATA_W +: DATA_W] =
        ((r_state != READY) || (w_idx == '0)) ? '0 :
        w_hit                                 ? w_byp :
                                                r_mem[w_idx];

`ifdef RF_SCOREBOARD_EN
    // A same-cycle write to the register hides its busy bit.
    assign rd_busy[r] = (r_state == READY) && (w_idx != '0) && !w_hit && r_busy[w_idx];
`endif
  end

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Directed self-checking bench for regfile_mp (default build;
//               busy-bit scenarios included when RF_SCOREBOARD_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int NRD    = 4;
  localparam int NWR    = 2;
  localparam int IDX_W  = 5;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NRD*IDX_W-1:0]  rd_idx;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NWR-1:0]        wr_en;
  logic [NWR*IDX_W-1:0]  wr_idx;
  logic [NWR*DATA_W-1:0] wr_data;
  logic                  ready;
`ifdef RF_SCOREBOARD_EN
  logic                  sb_set_en;
  logic [IDX_W-1:0]      sb_set_idx;
  logic [NRD-1:0]        rd_busy;
`endif

  int total = 0;
  int bad   = 0;

  regfile_mp #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .NRD    (NRD),
    .NWR    (NWR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
`ifdef RF_SCOREBOARD_EN
    .sb_set_en  (sb_set_en),
    .sb_set_idx (sb_set_idx),
    .rd_busy    (rd_busy),
`endif
    .ready      (ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rdd(input int r);
    return rd_data[r*DATA_W +: DATA_W];
  endfunction

  task automatic set_rd(input int r, input logic [IDX_W-1:0] v);
    rd_idx[r*IDX_W +: IDX_W] = v;
  endtask

  task automatic set_wr(input int p, input logic en, input logic [IDX_W-1:0] idx,
                        input logic [DATA_W-1:0] d);
    wr_en[p]                   = en;
    wr_idx[p*IDX_W +: IDX_W]   = idx;
    wr_data[p*DATA_W +: DATA_W] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset then idle: 32 cycles not ready, reads zero, CLEAR-time writes dropped.
  task automatic test_reset();
    reset = 1'b1;
    set_wr(0, 1'b1, 5'd9, 32'h0000_0099);
    set_rd(0, 5'd9);
    set_rd(1, 5'd1);
    set_rd(2, 5'd31);
    set_rd(3, 5'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < NREGS; k++) begin
      #1;
      total++;
      if (ready !== 1'b0) begin
        bad++;
        $display("FAIL reset_ready cyc=%0d: got %b expected 0", k, ready);
      end
      total++;
      if (rd_data !== '0) begin
        bad++;
        $display("FAIL reset_rdata cyc=%0d: got %h expected 0", k, rd_data);
      end
`ifdef RF_SCOREBOARD_EN
      total++;
      if (rd_busy !== '0) begin
        bad++;
        $display("FAIL reset_busy cyc=%0d: got %b expected 0", k, rd_busy);
      end
`endif
      tick();
    end
    wr_en = '0;
    #1;
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_clear: got %b expected 1", ready);
    end
    total++;
    if (rdd(0) !== 32'h0) begin
      bad++;
      $display("FAIL clear_write_dropped: got %h expected 0", rdd(0));
    end
    tick();
  endtask

  // Two ports write the same index: port 1 wins, both bypassed and stored.
  task automatic test_priority();
    set_wr(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    set_wr(1, 1'b1, 5'd5, 32'h1234_5678);
    set_rd(0, 5'd5);
    #1;
    total++;
    if (rdd(0) !== 32'h1234_5678) begin
      bad++;
      $display("FAIL prio_bypass: got %h expected 12345678", rdd(0));
    end
    tick();
    wr_en = '0;
    #1;
    total++;
    if (rdd(0) !== 32'h1234_5678) begin
      bad++;
      $display("FAIL prio_stored: got %h expected 12345678", rdd(0));
    end
    tick();
  endtask

  // Register 0 always reads zero, even with a same-cycle write to it.
  task automatic test_reg0();
    set_wr(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    set_rd(0, 5'd0);
    #1;
    total++;
    if (rdd(0) !== 32'h0) begin
      bad++;
      $display("FAIL reg0_bypass: got %h expected 0", rdd(0));
    end
    tick();
    wr_en = '0;
    #1;
    total++;
    if (rdd(0) !== 32'h0) begin
      bad++;
      $display("FAIL reg0_stored: got %h expected 0", rdd(0));
    end
    tick();
  endtask

  // Distinct writes on both ports, then four simultaneous reads.
  task automatic test_distinct();
    set_wr(0, 1'b1, 5'd1, 32'h11);
    set_wr(1, 1'b1, 5'd2, 32'h22);
    tick();
    set_wr(0, 1'b1, 5'd3, 32'h33);
    set_wr(1, 1'b1, 5'd4, 32'h44);
    set_rd(0, 5'd3);
    #1;
    total++;
    if (rdd(0) !== 32'h33) begin
      bad++;
      $display("FAIL port0_bypass: got %h expected 33", rdd(0));
    end
    tick();
    wr_en = '0;
    set_rd(0, 5'd1);
    set_rd(1, 5'd2);
    set_rd(2, 5'd3);
    set_rd(3, 5'd4);
    #1;
    for (int r = 0; r < NRD; r++) begin
      total++;
      if (rdd(r) !== 32'((r + 1) * 32'h11)) begin
        bad++;
        $display("FAIL distinct_rd%0d: got %h expected %h", r, rdd(r), 32'((r + 1) * 32'h11));
      end
    end
    tick();
  endtask

  // Reset mid-CLEAR restarts the sweep from entry 0.
  task automatic test_reset_mid();
    set_wr(0, 1'b1, 5'd3, 32'hA5A5_A5A5);
    tick();
    wr_en = '0;
    set_rd(0, 5'd3);
    #1;
    total++;
    if (rdd(0) !== 32'hA5A5_A5A5) begin
      bad++;
      $display("FAIL rm_written: got %h expected a5a5a5a5", rdd(0));
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (rdd(0) !== 32'h0) begin
      bad++;
      $display("FAIL rm_clear_read: got %h expected 0", rdd(0));
    end
    for (int k = 0; k < 10; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < NREGS - 1; k++) tick();
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL rm_ready_early: got %b expected 0", ready);
    end
    tick();
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL rm_ready: got %b expected 1", ready);
    end
    total++;
    if (rdd(0) !== 32'h0) begin
      bad++;
      $display("FAIL rm_idx3_zero: got %h expected 0", rdd(0));
    end
    tick();
  endtask

`ifdef RF_SCOREBOARD_EN
  // Busy bit set, write-clear bypass, and set-beats-clear tie.
  task automatic test_scoreboard();
    set_rd(1, 5'd7);
    sb_set_en  = 1'b1;
    sb_set_idx = 5'd7;
    #1;
    total++;
    if (rd_busy[1] !== 1'b0) begin
      bad++;
      $display("FAIL sb_set_same_cycle: got %b expected 0", rd_busy[1]);
    end
    tick();
    sb_set_en = 1'b0;
    #1;
    total++;
    if (rd_busy[1] !== 1'b1) begin
      bad++;
      $display("FAIL sb_set_next: got %b expected 1", rd_busy[1]);
    end
    set_wr(0, 1'b1, 5'd7, 32'h77);
    #1;
    total++;
    if (rd_busy[1] !== 1'b0) begin
      bad++;
      $display("FAIL sb_write_bypass: got %b expected 0", rd_busy[1]);
    end
    tick();
    wr_en = '0;
    #1;
    total++;
    if (rd_busy[1] !== 1'b0) begin
      bad++;
      $display("FAIL sb_write_cleared: got %b expected 0", rd_busy[1]);
    end
    sb_set_en = 1'b1;
    set_wr(0, 1'b1, 5'd7, 32'h78);
    tick();
    sb_set_en = 1'b0;
    wr_en     = '0;
    #1;
    total++;
    if (rd_busy[1] !== 1'b1) begin
      bad++;
      $display("FAIL sb_set_wins: got %b expected 1", rd_busy[1]);
    end
    tick();
  endtask
`endif

  initial begin
    reset   = 1'b0;
    rd_idx  = '0;
    wr_en   = '0;
    wr_idx  = '0;
    wr_data = '0;
`ifdef RF_SCOREBOARD_EN
    sb_set_en  = 1'b0;
    sb_set_idx = '0;
`endif
    test_reset();
    test_priority();
    test_reg0();
    test_distinct();
`ifdef RF_SCOREBOARD_EN
    test_scoreboard();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile_mp
`default_nettype wire
